// File: rtl/riscv_pkg.sv
// Shared RV32 core types: CSR address map, mstatus field positions and write masks.
package riscv_pkg;

   localparam int unsigned XLEN = 32;

   typedef logic [11:0] csr_t;

   localparam csr_t CSR_MSTATUS  = 12'h300;
   localparam csr_t CSR_MISA     = 12'h301;
   localparam csr_t CSR_MIE      = 12'h304;
   localparam csr_t CSR_MTVEC    = 12'h305;
   localparam csr_t CSR_MSCRATCH = 12'h340;
   localparam csr_t CSR_MEPC     = 12'h341;
   localparam csr_t CSR_MCAUSE   = 12'h342;
   localparam csr_t CSR_MTVAL    = 12'h343;
   localparam csr_t CSR_MIP      = 12'h344;
   localparam csr_t CSR_MCYCLE   = 12'hB00;
   localparam csr_t CSR_MINSTRET = 12'hB02;
   localparam csr_t CSR_MCYCLEH  = 12'hB80;
   localparam csr_t CSR_MINSTRETH= 12'hB82;
   localparam csr_t CSR_MHARTID  = 12'hF14;

   localparam int unsigned MSTATUS_MIE    = 3;
   localparam int unsigned MSTATUS_MPIE   = 7;
   localparam int unsigned MSTATUS_MPP_LO = 11;
   localparam int unsigned MSTATUS_MPP_HI = 12;

   localparam logic [XLEN-1:0] MSTATUS_WMASK = 32'h0000_1888;
   localparam logic [XLEN-1:0] MSTATUS_RESET = 32'h0000_1800;

   // Writable bits of each storage CSR; zero for read-only and unimplemented addresses.
   function automatic logic [XLEN-1:0] csr_wmask(input csr_t adr);
      case (adr)
         CSR_MSTATUS:                                   return MSTATUS_WMASK;
         CSR_MTVEC, CSR_MEPC:                           return ~32'h3;
         CSR_MIE, CSR_MSCRATCH, CSR_MCAUSE, CSR_MTVAL:  return '1;
         default:                                       return '0;
      endcase
   endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter with per-half load; a load in either half suppresses that cycle's increment.
// Latency: load/increment visible one cycle later; no backpressure.
module csr_counter64
   import riscv_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            inc_en,
   input  logic            wr_lo,
   input  logic            wr_hi,
   input  logic [XLEN-1:0] wr_dat,
   output logic [63:0]     cnt_q
);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (wr_lo || wr_hi) begin
         if (wr_lo) cnt_q[31:0]  <= wr_dat;
         if (wr_hi) cnt_q[63:32] <= wr_dat;
      end else if (inc_en) begin
         cnt_q <= cnt_q + 64'd1;
      end
   end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR storage: writes/traps land next cycle, reads are zero-latency with bypass; no backpressure.
// Optional mcycle/minstret counters built when CSR_COUNTERS_EN is defined.
module csr_file
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0000,
   parameter logic [XLEN-1:0] MISA_VAL    = 32'h4000_0100
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            csr_wbk_v_i,
   input  logic [11:0]     csr_adr_wbk_i,
   input  logic [XLEN-1:0] csr_data_wbk_i,
   input  logic            exception_i,
   input  logic [XLEN-1:0] mcause_i,
   input  logic [XLEN-1:0] mtval_i,
   input  logic [XLEN-1:0] mepc_i,
   input  logic [1:0]      core_mode_i,
   input  logic            retire_i,
   input  logic [11:0]     csr_rd_adr_i,
   input  logic            csr_rd_wr_i,
   output logic [XLEN-1:0] csr_rd_data_o,
   output logic            csr_illegal_o,
   output logic [XLEN-1:0] mepc_q_o,
   output logic [XLEN-1:0] mtvec_q_o,
   output logic [XLEN-1:0] mstatus_q_o
);

   localparam logic [XLEN-1:0] ALIGN4    = ~32'h3;
   localparam logic [XLEN-1:0] MTVEC_RST = MTVEC_RESET & ALIGN4;

   logic [XLEN-1:0] mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
   logic [XLEN-1:0] mstatus_cur, mie_cur, mtvec_cur, mscratch_cur, mepc_cur, mcause_cur, mtval_cur;
   logic [XLEN-1:0] mstatus_nxt, mie_nxt, mtvec_nxt, mscratch_nxt, mepc_nxt, mcause_nxt, mtval_nxt;
   logic [XLEN-1:0] wbk_dat_m;
   logic            wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause, wr_mtval;
   logic [XLEN-1:0] rd_cur, rd_nxt;
   logic            rd_impl, rd_trap_reg, rd_byp;

   assign wbk_dat_m   = csr_data_wbk_i & csr_wmask(csr_adr_wbk_i);
   assign wr_mstatus  = csr_wbk_v_i && (csr_adr_wbk_i == CSR_MSTATUS);
   assign wr_mie      = csr_wbk_v_i && (csr_adr_wbk_i == CSR_MIE);
   assign wr_mtvec    = csr_wbk_v_i && (csr_adr_wbk_i == CSR_MTVEC);
   assign wr_mscratch = csr_wbk_v_i && (csr_adr_wbk_i == CSR_MSCRATCH);
   assign wr_mepc     = csr_wbk_v_i && (csr_adr_wbk_i == CSR_MEPC);
   assign wr_mcause   = csr_wbk_v_i && (csr_adr_wbk_i == CSR_MCAUSE);
   assign wr_mtval    = csr_wbk_v_i && (csr_adr_wbk_i == CSR_MTVAL);

   // While reset is held, reads and next-state see the reset values, not stale storage.
   assign mstatus_cur  = reset ? MSTATUS_RESET : mstatus_q;
   assign mie_cur      = reset ? '0            : mie_q;
   assign mtvec_cur    = reset ? MTVEC_RST     : mtvec_q;
   assign mscratch_cur = reset ? '0            : mscratch_q;
   assign mepc_cur     = reset ? '0            : mepc_q;
   assign mcause_cur   = reset ? '0            : mcause_q;
   assign mtval_cur    = reset ? '0            : mtval_q;

   always_comb begin
      mstatus_nxt  = wr_mstatus  ? wbk_dat_m : mstatus_cur;
      mie_nxt      = wr_mie      ? wbk_dat_m : mie_cur;
      mtvec_nxt    = wr_mtvec    ? wbk_dat_m : mtvec_cur;
      mscratch_nxt = wr_mscratch ? wbk_dat_m : mscratch_cur;
      mepc_nxt     = wr_mepc     ? wbk_dat_m : mepc_cur;
      mcause_nxt   = wr_mcause   ? wbk_dat_m : mcause_cur;
      mtval_nxt    = wr_mtval    ? wbk_dat_m : mtval_cur;
      // Trap state overrides a same-cycle writeback to any trap register.
      if (exception_i) begin
         mstatus_nxt                               = mstatus_cur;
         mstatus_nxt[MSTATUS_MPIE]                 = mstatus_cur[MSTATUS_MIE];
         mstatus_nxt[MSTATUS_MIE]                  = 1'b0;
         mstatus_nxt[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = core_mode_i;
         mepc_nxt                                  = mepc_i & ALIGN4;
         mcause_nxt                                = mcause_i;
         mtval_nxt                                 = mtval_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mstatus_q  <= MSTATUS_RESET;
         mie_q      <= '0;
         mtvec_q    <= MTVEC_RST;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mtval_q    <= '0;
      end else begin
         mstatus_q  <= mstatus_nxt;
         mie_q      <= mie_nxt;
         mtvec_q    <= mtvec_nxt;
         mscratch_q <= mscratch_nxt;
         mepc_q     <= mepc_nxt;
         mcause_q   <= mcause_nxt;
         mtval_q    <= mtval_nxt;
      end
   end

`ifdef CSR_COUNTERS_EN
   logic [63:0] cycle_q, instret_q, cycle_cur, instret_cur;

   csr_counter64 u_mcycle (
      .clk    (clk),
      .reset  (reset),
      .inc_en (1'b1),
      .wr_lo  (csr_wbk_v_i && (csr_adr_wbk_i == CSR_MCYCLE)),
      .wr_hi  (csr_wbk_v_i && (csr_adr_wbk_i == CSR_MCYCLEH)),
      .wr_dat (csr_data_wbk_i),
      .cnt_q  (cycle_q)
   );

   csr_counter64 u_minstret (
      .clk    (clk),
      .reset  (reset),
      .inc_en (retire_i),
      .wr_lo  (csr_wbk_v_i && (csr_adr_wbk_i == CSR_MINSTRET)),
      .wr_hi  (csr_wbk_v_i && (csr_adr_wbk_i == CSR_MINSTRETH)),
      .wr_dat (csr_data_wbk_i),
      .cnt_q  (instret_q)
   );

   assign cycle_cur   = reset ? '0 : cycle_q;
   assign instret_cur = reset ? '0 : instret_q;
`else
   logic unused_retire;
   assign unused_retire = retire_i;
`endif

   always_comb begin
      rd_cur  = '0;
      rd_nxt  = '0;
      rd_impl = 1'b1;
      case (csr_rd_adr_i)
         CSR_MSTATUS:  begin rd_cur = mstatus_cur;  rd_nxt = mstatus_nxt;  end
         CSR_MISA:     begin rd_cur = MISA_VAL;     rd_nxt = MISA_VAL;     end
         CSR_MIE:      begin rd_cur = mie_cur;      rd_nxt = mie_nxt;      end
         CSR_MTVEC:    begin rd_cur = mtvec_cur;    rd_nxt = mtvec_nxt;    end
         CSR_MSCRATCH: begin rd_cur = mscratch_cur; rd_nxt = mscratch_nxt; end
         CSR_MEPC:     begin rd_cur = mepc_cur;     rd_nxt = mepc_nxt;     end
         CSR_MCAUSE:   begin rd_cur = mcause_cur;   rd_nxt = mcause_nxt;   end
         CSR_MTVAL:    begin rd_cur = mtval_cur;    rd_nxt = mtval_nxt;    end
         CSR_MIP, CSR_MHARTID: rd_impl = 1'b1;
`ifdef CSR_COUNTERS_EN
         CSR_MCYCLE:    begin rd_cur = cycle_cur[31:0];    rd_nxt = csr_data_wbk_i; end
         CSR_MCYCLEH:   begin rd_cur = cycle_cur[63:32];   rd_nxt = csr_data_wbk_i; end
         CSR_MINSTRET:  begin rd_cur = instret_cur[31:0];  rd_nxt = csr_data_wbk_i; end
         CSR_MINSTRETH: begin rd_cur = instret_cur[63:32]; rd_nxt = csr_data_wbk_i; end
`endif
         default: rd_impl = 1'b0;
      endcase
   end

   assign rd_trap_reg = (csr_rd_adr_i == CSR_MSTATUS) || (csr_rd_adr_i == CSR_MEPC) ||
                        (csr_rd_adr_i == CSR_MCAUSE)  || (csr_rd_adr_i == CSR_MTVAL);
   assign rd_byp      = (csr_wbk_v_i && (csr_adr_wbk_i == csr_rd_adr_i)) ||
                        (exception_i && rd_trap_reg);

   assign csr_rd_data_o = rd_byp ? rd_nxt : rd_cur;
   assign csr_illegal_o = !rd_impl ||
                          (core_mode_i < csr_rd_adr_i[9:8]) ||
                          (csr_rd_wr_i && (csr_rd_adr_i[11:10] == 2'b11));

   assign mepc_q_o    = mepc_q;
   assign mtvec_q_o   = mtvec_q;
   assign mstatus_q_o = mstatus_q;

endmodule

// File: tb/tb_csr_file.sv
// Randomised bench for csr_file against an address-indexed reference model of the CSR rules.
module tb_csr_file;
   import riscv_pkg::*;

   localparam logic [31:0] MTVEC_P = 32'h0000_2003;
   localparam logic [31:0] MISA_P  = 32'h4000_0100;
`ifdef CSR_COUNTERS_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, csr_wbk_v_i, exception_i, retire_i, csr_rd_wr_i;
   logic [11:0] csr_adr_wbk_i, csr_rd_adr_i;
   logic [31:0] csr_data_wbk_i, mcause_i, mtval_i, mepc_i;
   logic [1:0]  core_mode_i;
   logic [31:0] csr_rd_data_o, mepc_q_o, mtvec_q_o, mstatus_q_o;
   logic        csr_illegal_o;

   int checks   = 0;
   int failures = 0;

   csr_file #(.MTVEC_RESET(MTVEC_P), .MISA_VAL(MISA_P)) dut (
      .clk(clk), .reset(reset),
      .csr_wbk_v_i(csr_wbk_v_i), .csr_adr_wbk_i(csr_adr_wbk_i), .csr_data_wbk_i(csr_data_wbk_i),
      .exception_i(exception_i), .mcause_i(mcause_i), .mtval_i(mtval_i), .mepc_i(mepc_i),
      .core_mode_i(core_mode_i), .retire_i(retire_i),
      .csr_rd_adr_i(csr_rd_adr_i), .csr_rd_wr_i(csr_rd_wr_i),
      .csr_rd_data_o(csr_rd_data_o), .csr_illegal_o(csr_illegal_o),
      .mepc_q_o(mepc_q_o), .mtvec_q_o(mtvec_q_o), .mstatus_q_o(mstatus_q_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] st [csr_t];
   logic [63:0] m_cycle = '0, m_instret = '0;
   csr_t wr_regs [7] = '{CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL};
   csr_t pool [19]   = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                         12'h344, 12'hF14, 12'hB00, 12'hB02, 12'hB80, 12'hB82,
                         12'h7C0, 12'h302, 12'hB01, 12'h000, 12'hF11};

   function automatic bit is_cnt(csr_t a);
      return a inside {12'hB00, 12'hB02, 12'hB80, 12'hB82};
   endfunction

   function automatic bit m_impl(csr_t a);
      return st.exists(a) || (a inside {CSR_MISA, CSR_MIP, CSR_MHARTID}) || (CNT_EN && is_cnt(a));
   endfunction

   function automatic logic [31:0] m_mask(csr_t a);
      case (a)
         12'h300:                            return 32'h0000_1888;
         12'h305, 12'h341:                   return 32'hFFFF_FFFC;
         12'h304, 12'h340, 12'h342, 12'h343: return 32'hFFFF_FFFF;
         default:                            return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] m_rst(csr_t a);
      if (a == 12'h300) return 32'h0000_1800;
      if (a == 12'h305) return 32'h0000_2000;
      return 32'h0;
   endfunction

   function automatic logic [31:0] m_cur(csr_t a);
      if (!m_impl(a)) return 32'h0;
      if (a == CSR_MISA) return MISA_P;
      if (is_cnt(a)) begin
         if (reset) return 32'h0;
         case (a)
            12'hB00: return m_cycle[31:0];
            12'hB80: return m_cycle[63:32];
            12'hB02: return m_instret[31:0];
            default: return m_instret[63:32];
         endcase
      end
      if (st.exists(a)) return reset ? m_rst(a) : st[a];
      return 32'h0;
   endfunction

   function automatic logic [31:0] m_nxt(csr_t a);
      logic [31:0] v, old;
      old = m_cur(a);
      v   = old;
      if (csr_wbk_v_i && csr_adr_wbk_i == a) v = (v & ~m_mask(a)) | (csr_data_wbk_i & m_mask(a));
      if (exception_i) begin
         case (a)
            12'h341: v = mepc_i & 32'hFFFF_FFFC;
            12'h342: v = mcause_i;
            12'h343: v = mtval_i;
            12'h300: v = (old[3] ? 32'h80 : 32'h0) + 32'(core_mode_i) * 32'h800;
            default: ;
         endcase
      end
      return v;
   endfunction

   function automatic logic [31:0] m_read(csr_t a);
      bit wr_same;
      wr_same = csr_wbk_v_i && (csr_adr_wbk_i == a);
      if (!m_impl(a)) return 32'h0;
      if (is_cnt(a) && wr_same) return csr_data_wbk_i;
      if (st.exists(a) && (wr_same || (exception_i && (a inside {12'h300, 12'h341, 12'h342, 12'h343}))))
         return m_nxt(a);
      return m_cur(a);
   endfunction

   function automatic bit m_illegal(csr_t a);
      return !m_impl(a) || (core_mode_i < a[9:8]) || (csr_rd_wr_i && a[11:10] == 2'b11);
   endfunction

   function automatic logic [63:0] cnt_next(logic [63:0] c, csr_t lo, csr_t hi, bit inc);
      if (csr_wbk_v_i && csr_adr_wbk_i == lo) return {c[63:32], csr_data_wbk_i};
      if (csr_wbk_v_i && csr_adr_wbk_i == hi) return {csr_data_wbk_i, c[31:0]};
      return inc ? c + 64'd1 : c;
   endfunction

   task automatic m_clock();
      logic [31:0] nx [7];
      foreach (wr_regs[i]) nx[i] = reset ? m_rst(wr_regs[i]) : m_nxt(wr_regs[i]);
      foreach (wr_regs[i]) st[wr_regs[i]] = nx[i];
      if (reset) begin
         m_cycle   = '0;
         m_instret = '0;
      end else begin
         m_cycle   = cnt_next(m_cycle, 12'hB00, 12'hB80, 1'b1);
         m_instret = cnt_next(m_instret, 12'hB02, 12'hB82, retire_i);
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      reset = 1'b0; csr_wbk_v_i = 1'b0; csr_adr_wbk_i = '0; csr_data_wbk_i = '0;
      exception_i = 1'b0; mcause_i = '0; mtval_i = '0; mepc_i = '0;
      core_mode_i = 2'b11; retire_i = 1'b0; csr_rd_adr_i = 12'h300; csr_rd_wr_i = 1'b0;
   endtask

   // Called just after a falling edge with inputs set; returns at the next falling edge.
   task automatic cyc();
      #1;
      chk("rd_data", csr_rd_data_o, m_read(csr_rd_adr_i));
      chk("illegal", {31'b0, csr_illegal_o}, {31'b0, m_illegal(csr_rd_adr_i)});
      @(posedge clk);
      m_clock();
      #1;
      chk("mepc_q", mepc_q_o, st[CSR_MEPC]);
      chk("mtvec_q", mtvec_q_o, st[CSR_MTVEC]);
      chk("mstatus_q", mstatus_q_o, st[CSR_MSTATUS]);
      @(negedge clk);
   endtask

   task automatic rand_inputs();
      reset          = ($urandom_range(0, 49) == 0);
      csr_wbk_v_i    = 1'($urandom_range(0, 1));
      csr_adr_wbk_i  = pool[$urandom_range(0, 18)];
      csr_data_wbk_i = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      exception_i    = ($urandom_range(0, 9) == 0);
      mcause_i       = $urandom;
      mtval_i        = $urandom;
      mepc_i         = $urandom;
      core_mode_i    = 2'($urandom_range(0, 3));
      retire_i       = 1'($urandom_range(0, 1));
      csr_rd_adr_i   = ($urandom_range(0, 3) == 0) ? csr_adr_wbk_i : pool[$urandom_range(0, 18)];
      csr_rd_wr_i    = 1'($urandom_range(0, 1));
   endtask

   initial begin
      int n;
      foreach (wr_regs[i]) st[wr_regs[i]] = m_rst(wr_regs[i]);
      idle();
      reset = 1'b1;
      @(negedge clk);
      cyc();
      cyc();
      reset = 1'b0;
      chk("rst_mstatus", mstatus_q_o, 32'h0000_1800);
      chk("rst_mtvec", mtvec_q_o, 32'h0000_2000);
      csr_rd_adr_i = 12'h341;
      #1 chk("rst_mepc_rd", csr_rd_data_o, 32'h0);
      cyc();

      // mtvec low bits are forced clear
      idle(); csr_wbk_v_i = 1'b1; csr_adr_wbk_i = 12'h305; csr_data_wbk_i = 32'h8000_0103;
      cyc();
      chk("mtvec_mask", mtvec_q_o, 32'h8000_0100);

      idle(); csr_wbk_v_i = 1'b1; csr_adr_wbk_i = 12'h300; csr_data_wbk_i = 32'hFFFF_FFFF;
      cyc();
      idle(); csr_rd_adr_i = 12'h300;
      #1 chk("mstatus_mask", csr_rd_data_o, 32'h0000_1888);
      cyc();

      // trap beats a same-cycle mepc write
      idle(); core_mode_i = 2'b01; exception_i = 1'b1;
      mepc_i = 32'h1006; mcause_i = 32'd2; mtval_i = 32'h0;
      csr_wbk_v_i = 1'b1; csr_adr_wbk_i = 12'h341; csr_data_wbk_i = 32'h55;
      cyc();
      chk("trap_mepc", mepc_q_o, 32'h0000_1004);
      chk("trap_mstatus", mstatus_q_o, 32'h0000_0880);
      idle(); csr_rd_adr_i = 12'h342;
      #1 chk("trap_mcause", csr_rd_data_o, 32'd2);
      cyc();

      idle(); csr_wbk_v_i = 1'b1; csr_adr_wbk_i = 12'h340; csr_data_wbk_i = 32'hDEAD_BEEF;
      csr_rd_adr_i = 12'h340;
      #1 chk("bypass_mscratch", csr_rd_data_o, 32'hDEAD_BEEF);
      cyc();

      idle(); csr_rd_adr_i = 12'h7C0;
      #1 chk("ill_unimpl", {31'b0, csr_illegal_o}, 32'd1);
      cyc();
      idle(); csr_rd_adr_i = 12'hF14; csr_rd_wr_i = 1'b1;
      #1 chk("ill_ro_write", {31'b0, csr_illegal_o}, 32'd1);
      cyc();
      idle(); csr_rd_adr_i = 12'h300; core_mode_i = 2'b00;
      #1 chk("ill_priv_u", {31'b0, csr_illegal_o}, 32'd1);
      cyc();
      idle(); csr_rd_adr_i = 12'h300; core_mode_i = 2'b11;
      #1 chk("legal_priv_m", {31'b0, csr_illegal_o}, 32'd0);
      cyc();

`ifdef CSR_COUNTERS_EN
      idle(); reset = 1'b1;
      cyc();
      idle(); csr_wbk_v_i = 1'b1; csr_adr_wbk_i = 12'hB00; csr_data_wbk_i = 32'hFFFF_FFFF;
      cyc();
      idle(); csr_rd_adr_i = 12'hB00;
      #1 chk("mcycle_held", csr_rd_data_o, 32'hFFFF_FFFF);
      cyc();
      idle(); csr_rd_adr_i = 12'hB00;
      #1 chk("mcycle_wrap", csr_rd_data_o, 32'h0);
      cyc();
      idle(); csr_rd_adr_i = 12'hB80;
      #1 chk("mcycleh_carry", csr_rd_data_o, 32'h1);
      cyc();

      idle(); reset = 1'b1;
      cyc();
      n = 0;
      repeat (40) begin
         idle(); retire_i = 1'($urandom_range(0, 1));
         n += int'(retire_i);
         cyc();
      end
      idle(); csr_rd_adr_i = 12'hB02;
      #1 chk("minstret_count", csr_rd_data_o, 32'(n));
      cyc();
`else
      idle(); csr_rd_adr_i = 12'hB00;
      #1;
      chk("cnt_off_data", csr_rd_data_o, 32'h0);
      chk("cnt_off_ill", {31'b0, csr_illegal_o}, 32'd1);
      cyc();
`endif

      repeat (3000) begin
         rand_inputs();
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/csr_file.md
# csr_file

Machine-mode control and status register file: the storage side of the CSR path that the execute stage feeds. It captures CSR writebacks and trap state (mcause, mtval, mepc, mstatus stacking) registered by execute. It returns read data and legality to decode, and drives mepc/mtvec back to execute for trap entry and mret. The optional cycle and instret counters are included.

## Interface
Parameters:
- `MTVEC_RESET`, `32'h0000_0000`: mtvec reset value; bits [1:0] are forced to 0.
- `MISA_VAL`, `32'h4000_0100`: read-only misa value (RV32I).

Ports (`XLEN` = 32, from `riscv_pkg`):
- `clk` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `csr_wbk_v_i` in 1: CSR write valid, from execute `csr_wbk_v_q_o`.
- `csr_adr_wbk_i` in 12: write address.
- `csr_data_wbk_i` in XLEN: write data.
- `exception_i` in 1: trap taken this cycle, from execute `exception_q_o`.
- `mcause_i`, `mtval_i`, `mepc_i` in XLEN each: trap values.
- `core_mode_i` in 2: current privilege, from execute `core_mode_q_o`.
- `retire_i` in 1: one instruction retired this cycle.
- `csr_rd_adr_i` in 12: decode read address.
- `csr_rd_wr_i` in 1: decode instruction intends to write.
- `csr_rd_data_o` out XLEN: read data, combinational.
- `csr_illegal_o` out 1: access illegal, combinational.
- `mepc_q_o`, `mtvec_q_o`, `mstatus_q_o` out XLEN: registered copies to execute.

## Operation
Implemented CSRs. Read-only means writes are ignored.
- mstatus 0x300: only MIE[3], MPIE[7] and MPP[12:11] are writable; all other bits read 0.
- misa 0x301: read-only, `MISA_VAL`.
- mie 0x304: full 32-bit register.
- mtvec 0x305: bits [1:0] are forced to 0 (direct mode only).
- mscratch 0x340: full 32-bit register.
- mepc 0x341: bits [1:0] are forced to 0.
- mcause 0x342, mtval 0x343: full 32-bit registers.
- mip 0x344: read-only, 0.
- mhartid 0xF14: read-only, 0.
- Counters (see Configuration): mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82.

Write path:
- When `csr_wbk_v_i`=1, the addressed register is updated with its write mask applied.
- A write to an unimplemented or read-only address has no effect.

Trap entry, when `exception_i`=1:
- mepc ← `mepc_i` & ~3.
- mcause ← `mcause_i`.
- mtval ← `mtval_i`.
- mstatus.MPIE ← MIE, MIE ← 0, MPP ← `core_mode_i`.

Simultaneous events:
- Trap and CSR write to the same register: the trap wins.
- CSR write to a different register: both take effect.
- mret stacking arrives as an ordinary mstatus CSR write from execute; no special port exists.

Read path:
- `csr_rd_data_o` is the register value for `csr_rd_adr_i`.
- If `csr_wbk_v_i`=1 to the same address, the write-masked `csr_data_wbk_i` is returned instead (bypass).
- Counter reads bypass in the same way.
- During a trap, bypass data is the trap values.

`csr_illegal_o`=1 when any of:
- `csr_rd_adr_i` is unimplemented;
- `core_mode_i` < `csr_rd_adr_i[9:8]`;
- `csr_rd_wr_i`=1 and `csr_rd_adr_i[11:10]`==2'b11.

## Timing
- Writes and trap updates become visible on the `_q_o` outputs one cycle after the input cycle. Reads are zero-latency.
- Reset values:
  - mstatus 0x0000_1800 (MPP=11, MIE=0).
  - mtvec `MTVEC_RESET` & ~3.
  - All other registers and counters 0.
  - Outputs reflect these values in the cycle after `reset` is sampled high.
- Reset has priority over writes, traps and counter increments in the same cycle.
- While `reset`=1, the combinational outputs show reset state plus bypass. `csr_illegal_o` still evaluates.

## Configuration
- `CSR_COUNTERS_EN` defined:
  - mcycle/mcycleh form a 64-bit counter incrementing every cycle out of reset.
  - minstret/minstreth form a 64-bit counter incrementing when `retire_i`=1.
  - Both wrap from 2^64−1 to 0.
  - A CSR write to either half replaces that half in that cycle and suppresses the increment of the whole 64-bit counter for that cycle.
  - A carry out of the low half propagates to the high half in the same cycle.
- `CSR_COUNTERS_EN` undefined:
  - The four counter addresses are unimplemented (`csr_illegal_o`=1) and read 0.
  - `retire_i` is ignored.

## Structure
- Add to `riscv_pkg`:
  - CSR address constants (`CSR_MSTATUS` … `CSR_MHARTID`);
  - mstatus bit-position constants and `MSTATUS_WMASK` = 32'h0000_1888;
  - a `csr_t` typedef for the 12-bit address.
- Natural sub-module `csr_counter64`: a 64-bit counter with increment enable, low/high write enables and data. It is instantiated twice under `CSR_COUNTERS_EN`.

## Test plan
- Reset: hold `reset`=1 for 2 cycles → `mstatus_q_o`=0x1800, `mtvec_q_o`=`MTVEC_RESET`, read of 0x341 returns 0.
- Write and mask:
  - write 0x305 ← 0x8000_0103 → `mtvec_q_o`=0x8000_0100 next cycle;
  - write 0x300 ← 0xFFFF_FFFF → reads 0x1888.
- Trap over write:
  - preset MIE=1;
  - in the same cycle assert `exception_i` with `mepc_i`=0x1006, `mcause_i`=2, `mtval_i`=0, and a CSR write 0x341 ← 0x55;
  - → mepc=0x1004, mcause=2, MPIE=1, MIE=0, MPP=`core_mode_i`.
- Bypass: write 0x340 ← 0xDEAD_BEEF while `csr_rd_adr_i`=0x340 → `csr_rd_data_o`=0xDEAD_BEEF in the same cycle.
- Illegal:
  - read 0x7C0 → `csr_illegal_o`=1;
  - `csr_rd_wr_i`=1 on 0xF14 → 1;
  - `core_mode_i`=00 reading 0x300 → 1;
  - `core_mode_i`=11 reading 0x300 → 0.
- Counters (`CSR_COUNTERS_EN`):
  - write mcycle ← 0xFFFF_FFFF → next cycle holds it, the following cycle mcycle=0 and mcycleh=1;
  - minstret counts exactly the number of `retire_i` pulses.
